// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared state encoding and constants for the hazard controller
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_wait_timer.sv
// rtl/hazard_wait_timer.sv - counts consecutive data-memory wait cycles and flags the timeout
module hazard_wait_timer
  import hazard_pkg::*;
#(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The entry cycle loads 1, so reaching MEM_TIMEOUT-1 means MEM_TIMEOUT stalled cycles.
  assign expired = (cnt_q == TIMEOUT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - Mealy stall/flush sequencer for load-use, branch and memory-wait hazards
// Optional HAZARD_PERF_CNT_EN adds saturating STALL_CYCLES / FLUSH_EVENTS counters.
module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] ID_RS1,
  input  logic [REG_W-1:0] ID_RS2,
  input  logic [REG_W-1:0] EX_RD,
  input  logic             EX_MEM_READ,
  input  logic             EX_BRANCH_TAKEN,
  input  logic             MEM_REQ,
  input  logic             MEM_READY,
  output logic             PC_STALL,
  output logic             IF_ID_STALL,
  output logic             IF_ID_FLUSH,
  output logic             ID_EX_STALL,
  output logic             ID_EX_FLUSH,
  output logic             EX_MEM_STALL,
  output logic             MEM_WB_FLUSH,
  output logic             MEM_ERR,
  output logic [1:0]       STATE
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]      STALL_CYCLES,
  output logic [31:0]      FLUSH_EVENTS
`endif
);
  import hazard_pkg::*;

  state_e state_q, state_d;
  logic   pend_branch_q, pend_branch_d;
  logic   mem_err_q, mem_err_d;
  logic   tmr_clr, tmr_en, tmr_expired;
  logic   lu;

  assign lu = EX_MEM_READ && (EX_RD != REG_W'(REG_ZERO)) &&
              ((EX_RD == ID_RS1) || (EX_RD == ID_RS2));

  hazard_wait_timer #(
    .TIMEOUT_W  (TIMEOUT_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_expired)
  );

  always_comb begin
    state_d       = state_q;
    pend_branch_d = pend_branch_q;
    mem_err_d     = mem_err_q;
    tmr_clr       = 1'b0;
    tmr_en        = 1'b0;
    PC_STALL      = 1'b0;
    IF_ID_STALL   = 1'b0;
    IF_ID_FLUSH   = 1'b0;
    ID_EX_STALL   = 1'b0;
    ID_EX_FLUSH   = 1'b0;
    EX_MEM_STALL  = 1'b0;
    MEM_WB_FLUSH  = 1'b0;
    // Outputs are gated by rst so an asynchronous reset silences them in the same cycle.
    if (!rst) begin
      case (state_q)
        RUN: begin
          tmr_clr = 1'b1;
          if (MEM_REQ && !MEM_READY) begin
            {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_FLUSH} = 5'b11111;
            state_d       = MEM_WAIT;
            pend_branch_d = EX_BRANCH_TAKEN;
            tmr_clr       = 1'b0;
            tmr_en        = 1'b1;
          end else if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end else if (lu) begin
            PC_STALL    = 1'b1;
            IF_ID_STALL = 1'b1;
            ID_EX_FLUSH = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (MEM_READY) begin
            IF_ID_FLUSH   = pend_branch_q || EX_BRANCH_TAKEN;
            ID_EX_FLUSH   = pend_branch_q || EX_BRANCH_TAKEN;
            state_d       = RUN;
            pend_branch_d = 1'b0;
            tmr_clr       = 1'b1;
          end else begin
            {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL, MEM_WB_FLUSH} = 5'b11111;
            pend_branch_d = pend_branch_q || EX_BRANCH_TAKEN;
            if (tmr_expired) begin
              state_d   = ERROR;
              mem_err_d = 1'b1;
            end else begin
              tmr_en = 1'b1;
            end
          end
        end
        ERROR: begin
          {PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL} = 4'b1111;
        end
        default: begin
          state_d       = RUN;
          pend_branch_d = 1'b0;
          tmr_clr       = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pend_branch_q <= 1'b0;
      mem_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_branch_q <= pend_branch_d;
      mem_err_q     <= mem_err_d;
    end
  end

  assign MEM_ERR = mem_err_q;
  assign STATE   = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (PC_STALL && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (IF_ID_FLUSH && (flush_events_q != 32'hFFFF_FFFF)) begin
      flush_events_d = flush_events_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= 32'd0;
      flush_events_q <= 32'd0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign STALL_CYCLES = stall_cycles_q;
  assign FLUSH_EVENTS = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl (HAZARD_PERF_CNT_EN checks counters)
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] ID_RS1 = '0, ID_RS2 = '0, EX_RD = '0;
  logic       EX_MEM_READ = 1'b0, EX_BRANCH_TAKEN = 1'b0, MEM_REQ = 1'b0, MEM_READY = 1'b0;
  logic       PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_FLUSH;
  logic       EX_MEM_STALL, MEM_WB_FLUSH, MEM_ERR;
  logic [1:0] STATE;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] STALL_CYCLES, FLUSH_EVENTS;
`endif

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  localparam logic [6:0] Z  = 7'b0000000;
  localparam logic [6:0] S5 = 7'b1101011;
  localparam logic [6:0] FL = 7'b0010100;
  localparam logic [6:0] LU = 7'b1100100;
  localparam logic [6:0] ER = 7'b1101010;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } chk_t;

  chk_t sb_q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic [9:0] act;

  assign act = {STATE, PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_STALL, ID_EX_FLUSH,
                EX_MEM_STALL, MEM_WB_FLUSH, MEM_ERR};

  hazard_ctrl #(
    .REG_W      (5),
    .TIMEOUT_W  (8),
    .MEM_TIMEOUT(4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ID_RS1         (ID_RS1),
    .ID_RS2         (ID_RS2),
    .EX_RD          (EX_RD),
    .EX_MEM_READ    (EX_MEM_READ),
    .EX_BRANCH_TAKEN(EX_BRANCH_TAKEN),
    .MEM_REQ        (MEM_REQ),
    .MEM_READY      (MEM_READY),
    .PC_STALL       (PC_STALL),
    .IF_ID_STALL    (IF_ID_STALL),
    .IF_ID_FLUSH    (IF_ID_FLUSH),
    .ID_EX_STALL    (ID_EX_STALL),
    .ID_EX_FLUSH    (ID_EX_FLUSH),
    .EX_MEM_STALL   (EX_MEM_STALL),
    .MEM_WB_FLUSH   (MEM_WB_FLUSH),
    .MEM_ERR        (MEM_ERR),
    .STATE          (STATE)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .STALL_CYCLES   (STALL_CYCLES),
    .FLUSH_EVENTS   (FLUSH_EVENTS)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Applies one cycle of inputs just after the rising edge and queues the expected outputs.
  task automatic step(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic mr, input logic br, input logic req,
                      input logic rdy, input logic [1:0] st, input logic [6:0] o,
                      input logic err);
    chk_t c;
    @(posedge clk);
    #1;
    ID_RS1 = rs1; ID_RS2 = rs2; EX_RD = rd;
    EX_MEM_READ = mr; EX_BRANCH_TAKEN = br; MEM_REQ = req; MEM_READY = rdy;
    c.name = name;
    c.exp  = {st, o, err};
    sb_q.push_back(c);
  endtask

  always @(negedge clk) begin : monitor
    chk_t c;
    if (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      n_chk++;
      if (act !== c.exp) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b", c.name, act, c.exp);
      end
      n_chk++;
      if (IF_ID_STALL && IF_ID_FLUSH) begin
        n_fail++;
        $display("FAIL %s_stall_flush_excl: got both 1 expected not both", c.name);
      end
    end
  end

  initial begin
    step("reset", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, Z, 1'b0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    MEM_REQ = 1'b0; EX_BRANCH_TAKEN = 1'b0;

    step("mw_enter",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, S5, 1'b0);
    step("mw_wait1",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, S5, 1'b0);
    step("mw_wait2",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, S5, 1'b0);
    step("mw_release", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, Z,  1'b0);
    step("br_after",   5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, FL, 1'b0);
    step("mw_idle",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, Z,  1'b0);
`ifdef HAZARD_PERF_CNT_EN
    check32("perf_stall_cycles", STALL_CYCLES, 32'd3);
    check32("perf_flush_events", FLUSH_EVENTS, 32'd1);
`endif

    step("lu_rs2",     5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, LU, 1'b0);
    step("lu_rd0",     5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, Z,  1'b0);
    step("lu_rs1",     5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, LU, 1'b0);
    step("nolu_nomr",  5'd7, 5'd3, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, Z,  1'b0);
    step("br_over_lu", 5'd0, 5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, FL, 1'b0);

    step("pb_enter",   5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0, S5, 1'b0);
    step("pb_wait1",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, S5, 1'b0);
    step("pb_wait2",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, S5, 1'b0);
    step("pb_release", 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, FL, 1'b0);
    step("pb_lu_next", 5'd0, 5'd5, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, LU, 1'b0);
    step("pb_idle",    5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, Z,  1'b0);

    step("to_enter",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, S5, 1'b0);
    step("to_wait1",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, S5, 1'b0);
    step("to_wait2",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, S5, 1'b0);
    step("to_wait3",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, S5, 1'b0);
    step("to_error",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, ER, 1'b1);
    step("to_err_rdy", 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 2'd2, ER, 1'b1);

    @(posedge clk);
    #1;
    MEM_REQ = 1'b1; MEM_READY = 1'b0; EX_BRANCH_TAKEN = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check32("rst_async_outputs", {22'd0, act}, 32'd0);
    MEM_REQ = 1'b0;
    rst = 1'b0;

    step("post_rst",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, S5, 1'b0);
    step("post_rel",   5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd1, Z,  1'b0);
    step("final_idle", 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, Z,  1'b0);

    @(negedge clk);
    #1;
    check32("scoreboard_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage core.
- Drives the STALL/FLUSH inputs of pipe_if_id and the downstream pipeline registers, plus the PC write-enable.
- Resolves three hazard sources: load-use data hazards, taken branches in EX, and multi-cycle data-memory waits.
- Mealy style: outputs are combinational from the state register and current inputs, so they act in the same cycle.

Parameters:
- REG_W, 5, register-index width
- TIMEOUT_W, 8, width of the memory-wait timeout counter
- MEM_TIMEOUT, 200, maximum consecutive wait cycles before error

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ID_RS1  in  REG_W  source register 1 of the instruction in ID
- ID_RS2  in  REG_W  source register 2 of the instruction in ID
- EX_RD  in  REG_W  destination register of the instruction in EX
- EX_MEM_READ  in  1  instruction in EX is a load
- EX_BRANCH_TAKEN  in  1  EX resolved a taken branch or jump
- MEM_REQ  in  1  MEM stage has an active data-memory access
- MEM_READY  in  1  data memory completes the access this cycle
- PC_STALL  out  1  hold the PC
- IF_ID_STALL  out  1  to pipe_if_id STALL
- IF_ID_FLUSH  out  1  to pipe_if_id FLUSH
- ID_EX_STALL  out  1  hold the ID/EX register
- ID_EX_FLUSH  out  1  insert a bubble into ID/EX
- EX_MEM_STALL  out  1  hold the EX/MEM register
- MEM_WB_FLUSH  out  1  insert a bubble into MEM/WB
- MEM_ERR  out  1  sticky memory-timeout error
- STATE  out  2  current FSM state, for debug

Behaviour:
- Reset (async, rst=1): STATE=RUN, wait counter=0, pend_branch=0, MEM_ERR=0, all stall and flush outputs 0.
- States: RUN(0), MEM_WAIT(1), ERROR(2). Encoding 3 is illegal and returns to RUN.
- Load-use hazard (lu): EX_MEM_READ=1, EX_RD!=0, and (EX_RD==ID_RS1 or EX_RD==ID_RS2).
- RUN, evaluated in priority order:
  - MEM_REQ=1 and MEM_READY=0: PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_STALL and MEM_WB_FLUSH = 1. Go to MEM_WAIT. pend_branch <= EX_BRANCH_TAKEN. Counter <= 1.
  - Else EX_BRANCH_TAKEN=1: IF_ID_FLUSH=1 and ID_EX_FLUSH=1; stalls 0; PC loads the target externally. Takes priority over lu, because the ID instruction is wrong-path.
  - Else lu=1: PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1. Exactly one bubble, since the load advances to MEM next cycle.
  - Else all outputs 0.
- MEM_WAIT:
  - MEM_READY=0: same five stall/flush outputs as on entry. pend_branch |= EX_BRANCH_TAKEN. Counter increments.
  - Counter == MEM_TIMEOUT-1 with MEM_READY=0: go to ERROR and set MEM_ERR.
  - MEM_READY=1: all stalls drop this cycle. If pend_branch or EX_BRANCH_TAKEN, assert IF_ID_FLUSH and ID_EX_FLUSH. lu is ignored on this release cycle; it is re-evaluated next cycle. Go to RUN, clear pend_branch, counter <= 0.
- ERROR: PC, IF_ID, ID_EX and EX_MEM stalls held at 1; flushes 0; MEM_ERR=1. Only rst exits.
- MEM_READY=1 in RUN with MEM_REQ=1: no stall; the single-cycle access completes.
- rst during MEM_WAIT or ERROR: immediate return to RUN with all outputs 0; no pending flush survives.
- IF_ID_STALL and IF_ID_FLUSH are never 1 together (pipe_if_id gives FLUSH priority; this block must not rely on that).

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - Adds outputs STALL_CYCLES[31:0] and FLUSH_EVENTS[31:0], both async-reset to 0 and saturating at 32'hFFFFFFFF.
  - STALL_CYCLES increments on every cycle with PC_STALL=1.
  - FLUSH_EVENTS increments on every cycle with IF_ID_FLUSH=1.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package hazard_pkg: state enum (RUN, MEM_WAIT, ERROR); REG_ZERO constant (5'd0).
- Sub-module hazard_wait_timer owns the counter and the timeout compare.
  - Inputs: clk, rst, clr, en.
  - Output: expired.

Test Plan:
- Load-use: EX_MEM_READ=1, EX_RD=5, ID_RS2=5 -> one cycle with PC_STALL=1, IF_ID_STALL=1, ID_EX_FLUSH=1. With EX_RD=0 instead -> all outputs 0.
- Branch beats load-use: EX_BRANCH_TAKEN=1 together with the hazard above -> IF_ID_FLUSH=1, ID_EX_FLUSH=1, PC_STALL=0, IF_ID_STALL=0.
- Memory wait: MEM_REQ=1 with MEM_READY low for 3 cycles -> STATE=1 and the four stalls plus MEM_WB_FLUSH high for 3 cycles. On the 4th cycle MEM_READY=1 -> all outputs 0, STATE=0.
- Pending branch: EX_BRANCH_TAKEN pulsed only on the MEM_WAIT entry cycle, MEM_READY on cycle 3 -> release cycle shows IF_ID_FLUSH=1 and ID_EX_FLUSH=1.
- Timeout, with MEM_TIMEOUT=4: MEM_READY held low -> STATE=2 and MEM_ERR=1 after 4 cycles, stalls held. rst pulse mid-cycle -> outputs 0 immediately and STATE=0.
- HAZARD_PERF_CNT_EN build: run the memory-wait scenario, then one branch -> STALL_CYCLES=3, FLUSH_EVENTS=1.
